// File: rtl/tof_sequencer_if.sv
// Echo input and result handshake bundle for the ping sequencer.
// master = sequencer side, slave = echo source / result consumer.
interface tof_sequencer_if #(
    parameter int SAMPLE_W = 12,
    parameter int TOF_W    = 20
);
    logic                echo_valid_in;
    logic [SAMPLE_W-1:0] echo_sample_in;
    logic [SAMPLE_W-1:0] threshold_in;
    logic [TOF_W-1:0]    tof_out;
    logic                timeout_out;
    logic                tof_valid_out;
    logic                tof_ready_in;

    modport master (
        input  echo_valid_in, echo_sample_in, threshold_in, tof_ready_in,
        output tof_out, timeout_out, tof_valid_out
    );

    modport slave (
        output echo_valid_in, echo_sample_in, threshold_in, tof_ready_in,
        input  tof_out, timeout_out, tof_valid_out
    );
endinterface

// File: rtl/tof_sequencer.sv
// Per-ping sequencer: TX burst, receiver blanking, listen window, first-echo timestamp.
// All outputs registered; the result is held in REPORT until the consumer accepts it.
module tof_sequencer #(
    parameter int TX_HALF_PERIOD = 1875,
    parameter int TX_CYCLES      = 8,
    parameter int BLANK_CYCLES   = 15000,
    parameter int LISTEN_CYCLES  = 100000,
    parameter int SAMPLE_W       = 12,
    parameter int TOF_W          = 20
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 trigger_in,
    output logic                 tx_out,
    output logic                 tx_active_out,
    output logic                 busy_out,
    output logic                 missed_trigger_out,
    tof_sequencer_if.master      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_BLANK, S_LISTEN, S_REPORT
    } state_t;

    localparam int TX_LEN      = 2 * TX_CYCLES * TX_HALF_PERIOD;
    localparam int TX_LAST     = TX_LEN - 1;
    localparam int BLANK_LAST  = TX_LEN + BLANK_CYCLES - 1;
    localparam int LISTEN_LAST = BLANK_LAST + LISTEN_CYCLES;
    localparam int HW          = (TX_HALF_PERIOD > 1) ? $clog2(TX_HALF_PERIOD) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(TX_HALF_PERIOD - 1);

    state_t            r_state, w_state;
    logic [TOF_W-1:0]  r_cnt, w_cnt;
    logic [HW-1:0]     r_half, w_half;
    logic              r_tx, w_tx;
    logic [TOF_W-1:0]  r_tof, w_tof;
    logic              r_timeout, w_timeout;
    logic              r_valid, w_valid;
    logic              r_missed, w_missed;
    logic              r_tx_active, w_tx_active;
    logic              r_busy, w_busy;
    logic              w_hit;

    assign w_hit = bus.echo_valid_in && (bus.echo_sample_in >= bus.threshold_in);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_half      = r_half;
        w_tx        = 1'b0;
        w_tof       = r_tof;
        w_timeout   = r_timeout;
        w_valid     = 1'b0;
        w_missed    = trigger_in && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (trigger_in) begin
                    w_state = S_TX;
                    w_cnt   = '0;
                    w_half  = '0;
                    w_tx    = 1'b1;
                end
            end
            S_TX: begin
                w_cnt = r_cnt + TOF_W'(1);
                if (r_half == HALF_LAST) begin
                    w_half = '0;
                    w_tx   = ~r_tx;
                end else begin
                    w_half = r_half + HW'(1);
                    w_tx   = r_tx;
                end
                // Last burst cycle: force the drive low entering BLANK.
                if (r_cnt == TOF_W'(TX_LAST)) begin
                    w_state = S_BLANK;
                    w_tx    = 1'b0;
                end
            end
            S_BLANK: begin
                w_cnt = r_cnt + TOF_W'(1);
                if (r_cnt == TOF_W'(BLANK_LAST)) w_state = S_LISTEN;
            end
            S_LISTEN: begin
                w_cnt = r_cnt + TOF_W'(1);
                if (w_hit) begin
                    w_tof     = r_cnt;
                    w_timeout = 1'b0;
                    w_valid   = 1'b1;
                    w_state   = S_REPORT;
                end else if (r_cnt == TOF_W'(LISTEN_LAST)) begin
                    w_tof     = '1;
                    w_timeout = 1'b1;
                    w_valid   = 1'b1;
                    w_state   = S_REPORT;
                end
            end
            S_REPORT: begin
                w_valid = 1'b1;
                if (bus.tof_ready_in) begin
                    w_valid = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_tx_active = (w_state == S_TX);
        w_busy      = (w_state != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_half      <= '0;
            r_tx        <= 1'b0;
            r_tof       <= '0;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b0;
            r_missed    <= 1'b0;
            r_tx_active <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_half      <= w_half;
            r_tx        <= w_tx;
            r_tof       <= w_tof;
            r_timeout   <= w_timeout;
            r_valid     <= w_valid;
            r_missed    <= w_missed;
            r_tx_active <= w_tx_active;
            r_busy      <= w_busy;
        end
    end

    assign tx_out             = r_tx;
    assign tx_active_out      = r_tx_active;
    assign busy_out           = r_busy;
    assign missed_trigger_out = r_missed;
    assign bus.tof_out        = r_tof;
    assign bus.timeout_out    = r_timeout;
    assign bus.tof_valid_out  = r_valid;
endmodule

// File: tb/tb_tof_sequencer.sv
// Directed bench for tof_sequencer with shortened timing parameters:
// TX cnt 0-47 (16 half periods of 3), BLANK 48-77, LISTEN 78-177, all-ones = 8'hFF.
module tb_tof_sequencer;
    localparam int SW = 12;
    localparam int TW = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    logic trigger_in;
    logic tx_out, tx_active_out, busy_out, missed_trigger_out;

    tof_sequencer_if #(.SAMPLE_W(SW), .TOF_W(TW)) bus ();

    tof_sequencer #(
        .TX_HALF_PERIOD(3), .TX_CYCLES(8), .BLANK_CYCLES(30),
        .LISTEN_CYCLES(100), .SAMPLE_W(SW), .TOF_W(TW)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .trigger_in         (trigger_in),
        .tx_out             (tx_out),
        .tx_active_out      (tx_active_out),
        .busy_out           (busy_out),
        .missed_trigger_out (missed_trigger_out),
        .bus                (bus.master)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic step();
        tick();
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic start_ping();
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        cyc = 0;
    endtask

    task automatic hit(input logic [SW-1:0] sample);
        bus.echo_valid_in  = 1'b1;
        bus.echo_sample_in = sample;
        step();
        bus.echo_valid_in  = 1'b0;
        bus.echo_sample_in = '0;
    endtask

    initial begin
        int ones;
        int toggles;
        int valid_seen;
        logic prev;
        logic stable;

        rst_in = 1'b1;
        trigger_in = 1'b0;
        bus.echo_valid_in = 1'b0;
        bus.echo_sample_in = '0;
        bus.threshold_in = 12'h300;
        bus.tof_ready_in = 1'b0;

        // Reset with random inputs
        repeat (3) begin
            trigger_in         = 1'($urandom_range(0, 1));
            bus.echo_valid_in  = 1'($urandom_range(0, 1));
            bus.echo_sample_in = SW'($urandom);
            bus.tof_ready_in   = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_tx", tx_out, 0);
        check("rst_tx_active", tx_active_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_tof", bus.tof_out, 0);
        check("rst_timeout", bus.timeout_out, 0);
        check("rst_valid", bus.tof_valid_out, 0);
        check("rst_missed", missed_trigger_out, 0);

        rst_in = 1'b0;
        trigger_in = 1'b0;
        bus.echo_valid_in = 1'b0;
        bus.echo_sample_in = '0;
        bus.tof_ready_in = 1'b1;
        tick();
        check("idle_busy", busy_out, 0);

        // Nominal ping: burst shape and hit at cnt 120
        start_ping();
        check("nom_tx_start", tx_out, 1);
        check("nom_active_start", tx_active_out, 1);
        check("nom_busy_start", busy_out, 1);
        ones = 0; toggles = 0; prev = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (tx_out) ones++;
            if (tx_out !== prev) toggles++;
            prev = tx_out;
            step();
        end
        check("nom_tx_ones", ones, 24);
        check("nom_tx_toggles", toggles, 15);
        check("nom_tx_blank", tx_out, 0);
        check("nom_active_blank", tx_active_out, 0);
        check("nom_busy_blank", busy_out, 1);
        advance_to(120);
        hit(12'h400);
        check("nom_valid", bus.tof_valid_out, 1);
        check("nom_tof", bus.tof_out, 120);
        check("nom_timeout", bus.timeout_out, 0);
        step();
        check("nom_valid_drop", bus.tof_valid_out, 0);
        check("nom_idle", busy_out, 0);

        // Blanking and threshold edges
        start_ping();
        advance_to(60);
        hit(12'h400);
        check("blank_ignored", bus.tof_valid_out, 0);
        advance_to(100);
        hit(12'h2FF);
        check("below_thr_ignored", bus.tof_valid_out, 0);
        advance_to(130);
        hit(12'h300);
        check("eq_thr_valid", bus.tof_valid_out, 1);
        check("eq_thr_tof", bus.tof_out, 130);
        step();

        // Timeout with no hits
        start_ping();
        advance_to(178);
        check("to_valid", bus.tof_valid_out, 1);
        check("to_tof", bus.tof_out, 8'hFF);
        check("to_flag", bus.timeout_out, 1);
        step();
        check("to_valid_drop", bus.tof_valid_out, 0);

        // Hit on the last listen cycle
        start_ping();
        advance_to(177);
        hit(12'h400);
        check("last_hit_tof", bus.tof_out, 177);
        check("last_hit_flag", bus.timeout_out, 0);
        step();

        // Backpressure and missed triggers
        bus.tof_ready_in = 1'b0;
        start_ping();
        advance_to(10);
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        check("miss_tx_pulse", missed_trigger_out, 1);
        check("miss_tx_active", tx_active_out, 1);
        step();
        check("miss_tx_clear", missed_trigger_out, 0);
        advance_to(100);
        hit(12'h500);
        check("bp_tof", bus.tof_out, 100);
        stable = 1'b1;
        repeat (200) begin
            step();
            if (!(bus.tof_valid_out === 1'b1 && bus.tof_out === 8'd100 && bus.timeout_out === 1'b0))
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        bus.tof_ready_in = 1'b1;
        trigger_in = 1'b1;
        step();
        check("miss_rep_pulse", missed_trigger_out, 1);
        check("hs_valid_drop", bus.tof_valid_out, 0);
        check("hs_busy_drop", busy_out, 0);
        check("hs_no_burst", tx_active_out, 0);
        step();
        trigger_in = 1'b0;
        cyc = 0;
        check("retrig_tx", tx_out, 1);
        check("retrig_active", tx_active_out, 1);
        check("retrig_no_miss", missed_trigger_out, 0);
        advance_to(90);
        hit(12'h400);
        check("retrig_tof", bus.tof_out, 90);
        step();

        // Reset mid-burst
        start_ping();
        advance_to(12);
        check("mid_tx_high", tx_out, 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("mid_rst_tx", tx_out, 0);
        check("mid_rst_active", tx_active_out, 0);
        check("mid_rst_busy", busy_out, 0);
        valid_seen = 0;
        repeat (200) begin
            step();
            if (bus.tof_valid_out !== 1'b0) valid_seen++;
        end
        check("mid_rst_no_result", valid_seen, 0);
        start_ping();
        check("post_rst_tx", tx_out, 1);
        advance_to(140);
        hit(12'h400);
        check("post_rst_valid", bus.tof_valid_out, 1);
        check("post_rst_tof", bus.tof_out, 140);
        check("post_rst_timeout", bus.timeout_out, 0);
        step();
        check("post_rst_idle", busy_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
